// File: rtl/fir_result_reader.sv
// Streams sample_count bytes out of BRAM from base_addr, one read per sample.
// Latency: first out_valid 3 cycles after start; 3 cycles/sample with out_ready high.
// Backpressure: out_ready low parks the FSM in OUT with no further BRAM reads.
// Optional running checksum: define FIR_RESULT_CHECKSUM_EN.
module fir_result_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] sample_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    typedef enum logic [2:0] {IDLE, RD, WT, OUT, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] idx;
    logic              fin_hold;
    logic [ADDR_W-1:0] idx_next;
    logic              last;

    assign idx_next = idx + ADDR_W'(1);
    assign last     = (idx == count_q - ADDR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            count_q   <= '0;
            idx       <= '0;
            fin_hold  <= 1'b0;
            mem_addr  <= '0;
            mem_en    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= sample_count;
                        idx     <= '0;
                        busy    <= 1'b1;
                        // An empty request still spends two busy cycles in FIN
                        // so done lands at the same offset as a real readback tail.
                        if (sample_count == '0) begin
                            fin_hold <= 1'b1;
                            state    <= FIN;
                        end else begin
                            mem_en   <= 1'b1;
                            mem_addr <= base_addr;
                            state    <= RD;
                        end
                    end
                end
                RD: begin
                    mem_en <= 1'b0;
                    state  <= WT;
                end
                WT: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= idx_next;
                        if (last) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            mem_en   <= 1'b1;
                            mem_addr <= base_q + idx_next;
                            state    <= RD;
                        end
                    end
                end
                FIN: begin
                    if (fin_hold) begin
                        fin_hold <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_RESULT_CHECKSUM_EN
    logic [15:0] csum_q;
    logic        handshake;

    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (state == IDLE && start) begin
            csum_q <= '0;
        end else if (state == OUT && handshake) begin
            csum_q <= csum_q + 16'(out_data);
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_fir_result_reader.sv
// Self-checking bench for fir_result_reader: directed table, stall/poke/reset sequences, random transactions.
module tb_fir_result_reader;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] sample_count;
    logic [AW-1:0] mem_addr;
    logic          mem_en;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [15:0]   checksum;

    always #5 clk = ~clk;

    fir_result_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .sample_count (sample_count),
        .mem_addr     (mem_addr),
        .mem_en       (mem_en),
        .mem_rdata    (mem_rdata),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum)
    );

    // BRAM model: one-cycle read latency
    logic [DW-1:0] mem [MEMSZ];
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: hold ready low stall_len cycles on sample stall_idx
    task automatic run_txn(input string tag, input int base, input int cnt, input int mode,
                           input int stall_idx, input int stall_len, input bit poke,
                           output int first_cyc, output int done_cyc);
        int  addr_q[$];
        int  data_q[$];
        int  stalls, hs, done_cnt, busy_cyc, overlap, unstable, stall_left, cyc, exp_sum, ea;
        bit  prev_wait, finished;
        logic [DW-1:0] prev_data;
        stalls = 0; hs = 0; done_cnt = 0; busy_cyc = 0; overlap = 0; unstable = 0;
        stall_left = stall_len; prev_wait = 1'b0; finished = 1'b0; prev_data = '0;
        first_cyc = -1; done_cyc = -1;

        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); sample_count = AW'(cnt);
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); sample_count = AW'($urandom);
        cyc = 1;
        while (!finished && cyc <= 600) begin
            if (mem_en) addr_q.push_back(int'(mem_addr));
            if (mem_en && out_valid) overlap++;
            if (busy) busy_cyc++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (prev_wait && out_data != prev_data) unstable++;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    out_ready = 1'b1;
                    if (out_valid && hs == stall_idx && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end
                end
            endcase
            if (out_valid && out_ready) begin data_q.push_back(int'(out_data)); hs++; end
            else if (out_valid) stalls++;
            prev_wait = out_valid && !out_ready;
            prev_data = out_data;
            start = poke && (out_valid || done);
            if (start) begin base_addr = AW'($urandom); sample_count = AW'($urandom); end
            if (done_cnt > 0 && !busy) finished = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        start = 1'b0;
        if (!finished) check({tag, " timeout"}, 0, 1);

        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_cycle"}, done_cyc, (cnt == 0) ? 2 : 3 * cnt + 1 + stalls);
        check({tag, " busy_cycles"}, busy_cyc, (cnt == 0) ? 2 : 3 * cnt + 1 + stalls);
        check({tag, " first_valid"}, first_cyc, (cnt == 0) ? -1 : 3);
        check({tag, " n_reads"}, addr_q.size(), cnt);
        check({tag, " n_samples"}, data_q.size(), cnt);
        check({tag, " en_during_valid"}, overlap, 0);
        check({tag, " held_data_changed"}, unstable, 0);
        exp_sum = 0;
        for (int i = 0; i < cnt; i++) begin
            ea = (base + i) % MEMSZ;
            exp_sum = (exp_sum + int'(mem[ea])) % 65536;
            if (i < addr_q.size()) check($sformatf("%s addr[%0d]", tag, i), addr_q[i], ea);
            if (i < data_q.size()) check($sformatf("%s data[%0d]", tag, i), data_q[i], int'(mem[ea]));
        end
`ifdef FIR_RESULT_CHECKSUM_EN
        check({tag, " checksum"}, int'(checksum), exp_sum);
`else
        check({tag, " checksum"}, int'(checksum), 0);
`endif
    endtask

    typedef struct {
        int base;
        int cnt;
        int mode;
        int stall_idx;
        int stall_len;
        bit poke;
        int exp_first;
        int exp_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int f, d, n_en, dcount, bsy;
        vecs[0] = '{512,  4, 0, 0, 0,  1'b0,  3, 13};
        vecs[1] = '{1022, 4, 0, 0, 0,  1'b0,  3, 13};
        vecs[2] = '{1020, 8, 0, 0, 0,  1'b0,  3, 25};
        vecs[3] = '{100,  4, 2, 1, 10, 1'b0,  3, 23};
        vecs[4] = '{700,  0, 0, 0, 0,  1'b0, -1,  2};
        vecs[5] = '{300,  3, 0, 0, 0,  1'b1,  3, 10};

        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) mem[512 + i] = DW'(i + 1);
        mem[1022] = 8'hAA; mem[1023] = 8'hBB; mem[0] = 8'hCC; mem[1] = 8'hDD;
        for (int i = 0; i < 8; i++) mem[200 + i] = DW'(8'h10 + i);

        // reset together with start: reset must win
        rst = 1'b1; start = 1'b1; base_addr = 10'd5; sample_count = 10'd3; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset mem_en", int'(mem_en), 0);
        check("reset mem_addr", int'(mem_addr), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset done", int'(done), 0);
        check("reset checksum", int'(checksum), 0);
        rst = 1'b0; start = 1'b0;

        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].base, vecs[i].cnt, vecs[i].mode,
                    vecs[i].stall_idx, vecs[i].stall_len, vecs[i].poke, f, d);
            check($sformatf("vec%0d first_tbl", i), f, vecs[i].exp_first);
            check($sformatf("vec%0d done_tbl", i), d, vecs[i].exp_done);
        end

        // reset during sample 3 of 8
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd200; sample_count = 10'd8; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_en = 0;
        for (int c = 0; c < 100 && n_en < 3; c++) begin
            if (mem_en) n_en++;
            if (n_en < 3) begin @(posedge clk); #1; end
        end
        check("midrst reached_sample3", n_en, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", int'(busy), 0);
        check("midrst mem_en", int'(mem_en), 0);
        check("midrst mem_addr", int'(mem_addr), 0);
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst out_data", int'(out_data), 0);
        check("midrst checksum", int'(checksum), 0);
        dcount = 0; bsy = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) dcount++;
            if (busy) bsy++;
            @(posedge clk); #1;
        end
        check("midrst no_done", dcount, 0);
        check("midrst stays_idle", bsy, 0);
        run_txn("after_rst", 40, 3, 0, 0, 0, 1'b0, f, d);

        // randomized transactions against the reference model
        for (int r = 0; r < 10; r++) begin
            run_txn($sformatf("rnd%0d", r), int'($urandom_range(0, MEMSZ - 1)),
                    int'($urandom_range(0, 12)), 1, 0, 0, r[0], f, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
